// File: rtl/checker_ram_to_stream.sv
// rtl/checker_ram_to_stream.sv - sequential reader of the interleaved checker RAM into a 64-bit beat stream
//
// Purpose: fetches cmd_len_i beats of two consecutive 32-bit words {w+1,w}, starting at word
// cmd_adr_i, from eight byte-wide banks (even words in banks 0-3, odd words in banks 4-7, both
// at w>>1). Each beat is read in one RAM cycle, buffered in a small FIFO, and then delivered
// on a valid/ready stream.
//
// Ports:
//   sys_clk, sys_rst_n            clock, asynchronous active-low reset
//   cmd_start_i/adr_i/len_i       start pulse, first word index, beat count (ignored while busy)
//   abort_i                       cancel the transfer and flush everything buffered
//   busy_o, done_o                transfer in progress; 1-cycle completion pulse
//   ram_adr_lo_o/hi_o, ram_re_o   bank addresses (banks 0-3 / 4-7) and read enable
//   ram_dat_i                     read data, byte k from bank k, one cycle after ram_re_o
//   st_dat_o/valid_o/ready_i/last_o  output beat stream
module checker_ram_to_stream #(
  parameter int WADR_W     = 13,
  parameter int LEN_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cmd_start_i,
  input  logic [WADR_W-1:0] cmd_adr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WADR_W-2:0] ram_adr_lo_o,
  output logic [WADR_W-2:0] ram_adr_hi_o,
  output logic              ram_re_o,
  input  logic [63:0]       ram_dat_i,
  output logic [63:0]       st_dat_o,
  output logic              st_valid_o,
  input  logic              st_ready_i,
  output logic              st_last_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WADR_W-1:0] w_q, w_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic              par_q, par_d;
  logic              rlast_q, rlast_d;
  logic [64:0]       mem_q [FIFO_DEPTH];
  logic [64:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              issue;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    credit_used;
  logic [63:0]       beat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    // Credit uses registered counts only, so st_ready_i never reaches the RAM side.
    credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    issue       = (state_q == S_READ) && !abort_i && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    push        = inflight_q;
    pop         = (count_q != '0) && st_ready_i;
    // Odd start word: word w came from the high banks, word w+1 from the low banks.
    beat        = par_q ? {ram_dat_i[31:0], ram_dat_i[63:32]} : ram_dat_i;
  end

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    rem_d      = rem_q;
    inflight_d = issue;
    par_d      = par_q;
    rlast_d    = rlast_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (issue) begin
      w_d     = w_q + WADR_W'(2);
      rem_d   = rem_q - LEN_W'(1);
      par_d   = w_q[0];
      rlast_d = (rem_q == LEN_W'(1));
    end

    if (push) begin
      mem_d[wr_ptr_q] = {rlast_q, beat};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (cmd_start_i) begin
          w_d     = cmd_adr_i;
          rem_d   = cmd_len_i;
          state_d = (cmd_len_i == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (issue && (rem_q == LEN_W'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && mem_q[rd_ptr_q][64]) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a start in the same cycle.
    if (abort_i) begin
      state_d    = S_IDLE;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      w_q        <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      par_q      <= 1'b0;
      rlast_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      par_q      <= par_d;
      rlast_q    <= rlast_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign busy_o       = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done_o       = (state_q == S_DONE);
  assign ram_re_o     = issue;
  // ((w+1) mod 2^WADR_W) >> 1 without a spare carry bit; wraps to 0 at the top word.
  assign ram_adr_lo_o = w_q[WADR_W-1:1] + (WADR_W - 1)'(w_q[0]);
  assign ram_adr_hi_o = w_q[WADR_W-1:1];
  assign st_valid_o   = (count_q != '0);
  assign st_dat_o     = mem_q[rd_ptr_q][63:0];
  assign st_last_o    = st_valid_o && mem_q[rd_ptr_q][64];

endmodule

// File: tb/tb_checker_ram_to_stream.sv
// tb/tb_checker_ram_to_stream.sv - directed self-checking bench for checker_ram_to_stream
module tb_checker_ram_to_stream;

  localparam int DEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        cmd_start_i;
  logic [12:0] cmd_adr_i;
  logic [12:0] cmd_len_i;
  logic        abort_i;
  logic        busy_o, done_o, ram_re_o;
  logic [11:0] ram_adr_lo_o, ram_adr_hi_o;
  logic [63:0] ram_dat_i = '0;
  logic [63:0] st_dat_o;
  logic        st_valid_o, st_ready_i, st_last_o;

  checker_ram_to_stream #(.WADR_W(13), .LEN_W(13), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_start_i(cmd_start_i), .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .ram_adr_lo_o(ram_adr_lo_o), .ram_adr_hi_o(ram_adr_hi_o), .ram_re_o(ram_re_o),
    .ram_dat_i(ram_dat_i), .st_dat_o(st_dat_o), .st_valid_o(st_valid_o),
    .st_ready_i(st_ready_i), .st_last_o(st_last_o)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] word(input logic [12:0] i);
    return 32'hA000_0000 + {19'd0, i};
  endfunction

  function automatic logic [63:0] beat_of(input logic [12:0] w);
    logic [12:0] w1;
    w1 = w + 13'd1;
    return {word(w1), word(w)};
  endfunction

  // RAM model: low banks hold even word 2*lo, high banks hold odd word 2*hi+1.
  always @(posedge sys_clk)
    if (ram_re_o) ram_dat_i <= {word({ram_adr_hi_o, 1'b1}), word({ram_adr_lo_o, 1'b0})};

  int          tests = 0, fails = 0;
  int          cyc_n = 0, first_v, first_re, done_n, done_cyc, s;
  int          tb_cnt = 0, tb_infl = 0;
  logic        mon_on = 1'b0, stall_prev = 1'b0;
  logic [64:0] hold;
  logic [64:0] rx[$];
  logic [23:0] iss[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rx.delete(); iss.delete();
    first_v = -1; first_re = -1; done_n = 0; done_cyc = -1;
  endtask

  // Observe one cycle with the inputs already applied, then advance to the next negedge.
  task automatic step();
    #1;
    cyc_n++;
    if (mon_on) begin
      chk("valid_vs_model", 64'(st_valid_o), 64'(tb_cnt != 0));
      if (ram_re_o) chk("credit", 64'(tb_cnt + tb_infl < DEPTH), 64'd1);
      if (stall_prev) begin
        chk("stall_dat", st_dat_o, hold[63:0]);
        chk("stall_last", 64'(st_last_o), 64'(hold[64]));
      end
    end
    if (st_valid_o && st_ready_i && !abort_i) rx.push_back({st_last_o, st_dat_o});
    if (ram_re_o) begin
      iss.push_back({ram_adr_lo_o, ram_adr_hi_o});
      if (first_re < 0) first_re = cyc_n;
    end
    if (st_valid_o && first_v < 0) first_v = cyc_n;
    if (done_o) begin done_n++; done_cyc = cyc_n; end
    stall_prev = st_valid_o && !st_ready_i && !abort_i && sys_rst_n;
    hold = {st_last_o, st_dat_o};
    if (abort_i || !sys_rst_n) begin
      tb_cnt = 0; tb_infl = 0;
    end else begin
      tb_cnt  = tb_cnt + tb_infl - ((st_valid_o && st_ready_i) ? 1 : 0);
      tb_infl = ram_re_o ? 1 : 0;
    end
    @(negedge sys_clk);
  endtask

  task automatic run_xfer(input logic [12:0] adr, input logic [12:0] len, input bit rnd,
                          input int budget, output int s0);
    clr();
    cmd_start_i = 1'b1; cmd_adr_i = adr; cmd_len_i = len; st_ready_i = 1'b1;
    s0 = cyc_n + 1;
    step();
    cmd_start_i = 1'b0;
    for (int k = 0; k < budget && done_n == 0; k++) begin
      if (rnd) st_ready_i = ($urandom_range(0, 99) >= 30);
      step();
    end
    chk("done_seen", 64'(done_n), 64'd1);
    st_ready_i = 1'b1;
  endtask

  task automatic chk_beats(input logic [12:0] w0, input int n);
    logic [12:0] w;
    chk("beat_count", 64'(rx.size()), 64'(n));
    for (int i = 0; i < n && i < rx.size(); i++) begin
      w = w0 + 13'(2 * i);
      chk($sformatf("beat%0d_dat", i), rx[i][63:0], beat_of(w));
      chk($sformatf("beat%0d_last", i), 64'(rx[i][64]), 64'(i == n - 1));
    end
  endtask

  initial begin
    sys_rst_n = 1'b0; cmd_start_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0;
    abort_i = 1'b0; st_ready_i = 1'b1;
    clr();
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_re", 64'(ram_re_o), 64'd0);
    chk("rst_valid", 64'(st_valid_o), 64'd0);
    chk("rst_last", 64'(st_last_o), 64'd0);
    chk("rst_adr", 64'({ram_adr_lo_o, ram_adr_hi_o}), 64'd0);
    chk("rst_dat", st_dat_o, 64'd0);
    sys_rst_n = 1'b1; mon_on = 1'b1;
    step();

    // Even start, full rate
    run_xfer(13'd0, 13'd4, 1'b0, 40, s);
    chk_beats(13'd0, 4);
    chk("t1_first_re", 64'(first_re), 64'(s + 1));
    chk("t1_first_valid", 64'(first_v), 64'(s + 3));
    chk("t1_done_cyc", 64'(done_cyc), 64'(s + 7));
    chk("t1_adr0", 64'(iss[0]), 64'd0);
    step(); step();
    chk("t1_done_single", 64'(done_n), 64'd1);
    chk("t1_idle", 64'(busy_o), 64'd0);

    // Odd start
    run_xfer(13'd5, 13'd2, 1'b0, 40, s);
    chk_beats(13'd5, 2);
    chk("t2_iss_n", 64'(iss.size()), 64'd2);
    chk("t2_adr0", 64'(iss[0]), 64'({12'd3, 12'd2}));
    chk("t2_adr1", 64'(iss[1]), 64'({12'd4, 12'd3}));

    // Top-word wrap
    run_xfer(13'd8191, 13'd1, 1'b0, 40, s);
    chk("t3_beat", rx[0][63:0], 64'hA000_0000_A000_1FFF);
    chk("t3_adr", 64'(iss[0]), 64'({12'd0, 12'd4095}));

    // Random backpressure
    run_xfer(13'd100, 13'd16, 1'b1, 400, s);
    chk_beats(13'd100, 16);
    chk("t4_iss_n", 64'(iss.size()), 64'd16);

    // Zero length
    run_xfer(13'd200, 13'd0, 1'b0, 10, s);
    chk("t5_done_cyc", 64'(done_cyc), 64'(s + 1));
    chk("t5_no_valid", 64'(first_v), 64'(-1));
    chk("t5_no_read", 64'(iss.size()), 64'd0);

    // Start while busy is ignored
    clr();
    cmd_start_i = 1'b1; cmd_adr_i = 13'd20; cmd_len_i = 13'd4;
    step();
    cmd_start_i = 1'b0;
    step();
    cmd_start_i = 1'b1; cmd_adr_i = 13'd999; cmd_len_i = 13'd9;
    step();
    cmd_start_i = 1'b0;
    for (int k = 0; k < 40 && done_n == 0; k++) step();
    repeat (6) step();
    chk_beats(13'd20, 4);
    chk("t6_done_n", 64'(done_n), 64'd1);

    // Abort at beat 3
    clr();
    cmd_start_i = 1'b1; cmd_adr_i = 13'd40; cmd_len_i = 13'd8;
    step();
    cmd_start_i = 1'b0;
    for (int k = 0; k < 40 && rx.size() < 3; k++) step();
    chk("t7_reach", 64'(rx.size()), 64'd3);
    abort_i = 1'b1; st_ready_i = 1'b0;
    step();
    abort_i = 1'b0; st_ready_i = 1'b1;
    chk("t7_busy", 64'(busy_o), 64'd0);
    chk("t7_valid", 64'(st_valid_o), 64'd0);
    repeat (10) step();
    chk("t7_no_done", 64'(done_n), 64'd0);
    chk("t7_no_more", 64'(rx.size()), 64'd3);

    // Reset mid-transfer
    clr();
    cmd_start_i = 1'b1; cmd_adr_i = 13'd300; cmd_len_i = 13'd8;
    step();
    cmd_start_i = 1'b0;
    for (int k = 0; k < 40 && rx.size() < 2; k++) step();
    chk("t8_reach", 64'(rx.size()), 64'd2);
    sys_rst_n = 1'b0; tb_cnt = 0; tb_infl = 0; stall_prev = 1'b0;
    step();
    chk("t8_busy", 64'(busy_o), 64'd0);
    chk("t8_valid", 64'(st_valid_o), 64'd0);
    chk("t8_re", 64'(ram_re_o), 64'd0);
    sys_rst_n = 1'b1;
    repeat (8) step();
    chk("t8_no_done", 64'(done_n), 64'd0);
    chk("t8_no_more", 64'(rx.size()), 64'd2);

    // Clean restart
    run_xfer(13'd60, 13'd3, 1'b0, 40, s);
    chk_beats(13'd60, 3);
    chk("t9_first_valid", 64'(first_v), 64'(s + 3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
